// File: rtl/mysystem_onchip_memory_dp_pkg.sv
// Shared types and constants for the dual-port on-chip memory.
// The clear FSM state encoding and parameter sanity helpers live here.
package mysystem_onchip_mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int DEF_DATA_W   = 32;
    localparam int BE_W         = DEF_DATA_W / 8;
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    function automatic bit read_lat_ok(input int lat);
        return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
    endfunction

    function automatic int be_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mysystem_onchip_memory_dp_if.sv
// Avalon-MM slave port bundle; one instance per memory port.
interface mysystem_onchip_memory_dp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0]   address;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/mysystem_tdp_ram_core.sv
// Inferred true-dual-port byte-enable RAM. Reads return pre-write contents;
// on a same-address write collision port A's lanes override port B's.
module mysystem_tdp_ram_core
    import mysystem_onchip_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic                      clk,
    input  logic [ADDR_W-1:0]         i_addr_a,
    input  logic [be_w(DATA_W)-1:0]   i_we_a,
    input  logic                      i_re_a,
    input  logic [DATA_W-1:0]         i_wd_a,
    output logic [DATA_W-1:0]         o_rd_a,
    input  logic [ADDR_W-1:0]         i_addr_b,
    input  logic [be_w(DATA_W)-1:0]   i_we_b,
    input  logic                      i_re_b,
    input  logic [DATA_W-1:0]         i_wd_b,
    output logic [DATA_W-1:0]         o_rd_b
);
    localparam int NBE   = be_w(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [NBE-1:0][7:0] r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rd_a;
    logic [DATA_W-1:0]   r_rd_b;

    // Port A lanes are written last so they win when both ports hit one word.
    always_ff @(posedge clk) begin
        if (i_re_a) r_rd_a <= r_mem[i_addr_a];
        if (i_re_b) r_rd_b <= r_mem[i_addr_b];
        for (int l = 0; l < NBE; l++) begin
            if (i_we_b[l]) r_mem[i_addr_b][l] <= i_wd_b[l*8 +: 8];
            if (i_we_a[l]) r_mem[i_addr_a][l] <= i_wd_a[l*8 +: 8];
        end
    end

    assign o_rd_a = r_rd_a;
    assign o_rd_b = r_rd_b;

endmodule

// File: rtl/mysystem_onchip_memory_dp.sv
// Dual Avalon-MM slave RAM: power-on clear sequencer on port A, then two
// independent ports with a fixed READ_LAT read pipeline each.
module mysystem_onchip_memory_dp
    import mysystem_onchip_mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 12,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clken,
    mysystem_onchip_memory_dp_if.slave  s1,
    mysystem_onchip_memory_dp_if.slave  s2
);
    localparam int NBE = be_w(DATA_W);
    localparam int NP  = 2;

    if (!read_lat_ok(READ_LAT) || (DATA_W % 8) != 0) begin : g_bad_param
        $error("mysystem_onchip_memory_dp: illegal READ_LAT or DATA_W");
    end

    state_e            r_state;
    state_e            w_state_nxt;
    logic              w_clearing;
    logic [ADDR_W-1:0] r_clr_cnt;

    logic [NP-1:0]              w_cs, w_rd, w_wr, w_acc, w_re, w_we, w_rvalid;
    logic [NP-1:0][ADDR_W-1:0]  w_addr;
    logic [NP-1:0][NBE-1:0]     w_be;
    logic [NP-1:0][DATA_W-1:0]  w_wd, w_q, w_rdata;

    logic [ADDR_W-1:0] w_a_addr;
    logic [NBE-1:0]    w_a_we, w_b_we;
    logic [DATA_W-1:0] w_a_wd;

    assign w_cs   = {s2.chipselect, s1.chipselect};
    assign w_rd   = {s2.read,       s1.read};
    assign w_wr   = {s2.write,      s1.write};
    assign w_addr = {s2.address,    s1.address};
    assign w_be   = {s2.byteenable, s1.byteenable};
    assign w_wd   = {s2.writedata,  s1.writedata};

    assign s1.readdata      = w_rdata[0];
    assign s1.readdatavalid = w_rvalid[0];
    assign s1.waitrequest   = w_clearing;
    assign s2.readdata      = w_rdata[1];
    assign s2.readdatavalid = w_rvalid[1];
    assign s2.waitrequest   = w_clearing;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clearing  = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clearing = 1'b1;
                if (clken && (&r_clr_cnt)) w_state_nxt = ST_READY;
            end
            default: ;
        endcase
    end

    // Counter wraps back to 0 on the final word, ready for a later reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                r_clr_cnt <= '0;
        else if (w_clearing && clken) r_clr_cnt <= r_clr_cnt + 1'b1;
    end

    assign w_a_addr = w_clearing ? r_clr_cnt : w_addr[0];
    assign w_a_we   = w_clearing ? {NBE{clken}} : (w_we[0] ? w_be[0] : '0);
    assign w_a_wd   = w_clearing ? '0 : w_wd[0];
    assign w_b_we   = w_we[1] ? w_be[1] : '0;

    mysystem_tdp_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk      (clk),
        .i_addr_a (w_a_addr),
        .i_we_a   (w_a_we),
        .i_re_a   (w_re[0]),
        .i_wd_a   (w_a_wd),
        .o_rd_a   (w_q[0]),
        .i_addr_b (w_addr[1]),
        .i_we_b   (w_b_we),
        .i_re_b   (w_re[1]),
        .i_wd_b   (w_wd[1]),
        .o_rd_b   (w_q[1])
    );

    for (genvar p = 0; p < NP; p++) begin : g_port
        logic [READ_LAT:0]   vld_pipe;
        logic [READ_LAT-1:0] r_vld_sr;
        logic [DATA_W-1:0]   r_hold;
        logic [DATA_W-1:0]   w_out;

        assign w_acc[p] = w_cs[p] & (w_rd[p] | w_wr[p]) & ~w_clearing & clken;
        assign w_we[p]  = w_acc[p] & w_wr[p];
        assign w_re[p]  = w_acc[p] & w_rd[p] & ~w_wr[p];
        assign vld_pipe = {r_vld_sr, w_re[p]};

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)   r_vld_sr <= '0;
            else if (clken) r_vld_sr <= vld_pipe[READ_LAT-1:0];
        end

        if (READ_LAT == 1) begin : g_lat1
            assign w_out = w_q[p];
        end else begin : g_lat2
            logic [DATA_W-1:0] r_d2;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)                  r_d2 <= '0;
                else if (clken && vld_pipe[1]) r_d2 <= w_q[p];
            end
            assign w_out = r_d2;
        end

        // A stalled valid stays in the pipe and is released once clken returns.
        assign w_rvalid[p] = vld_pipe[READ_LAT] & clken;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)         r_hold <= '0;
            else if (w_rvalid[p]) r_hold <= w_out;
        end

        assign w_rdata[p] = w_rvalid[p] ? w_out : r_hold;

        a_rw_drop: assert property (@(posedge clk) disable iff (!reset_n)
            !(w_acc[p] && w_rd[p] && w_wr[p]));
    end

endmodule

// File: tb/tb_mysystem_onchip_memory_dp.sv
// Directed bench: dut1 is READ_LAT=1, dut2 is READ_LAT=2; both 32x16 with clear.
module tb_mysystem_onchip_memory_dp;

    logic clk = 1'b0;
    logic reset_n;
    logic clken1, clken2;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mysystem_onchip_memory_dp_if #(.DATA_W(32), .ADDR_W(4)) a_s1 ();
    mysystem_onchip_memory_dp_if #(.DATA_W(32), .ADDR_W(4)) a_s2 ();
    mysystem_onchip_memory_dp_if #(.DATA_W(32), .ADDR_W(4)) b_s1 ();
    mysystem_onchip_memory_dp_if #(.DATA_W(32), .ADDR_W(4)) b_s2 ();

    mysystem_onchip_memory_dp #(.DATA_W(32), .ADDR_W(4), .READ_LAT(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .clken(clken1), .s1(a_s1), .s2(a_s2));
    mysystem_onchip_memory_dp #(.DATA_W(32), .ADDR_W(4), .READ_LAT(2), .CLEAR_ON_RESET(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .clken(clken2), .s1(b_s1), .s2(b_s2));

    typedef struct {
        bit          port;
        bit          wr;
        logic [3:0]  addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drv(input int d, input int p, input bit cs, input bit rd, input bit wr,
                       input logic [3:0] a, input logic [3:0] be, input logic [31:0] wd);
        case ({d[1:0], p[0]})
            3'b010: begin a_s1.chipselect = cs; a_s1.read = rd; a_s1.write = wr;
                          a_s1.address = a; a_s1.byteenable = be; a_s1.writedata = wd; end
            3'b011: begin a_s2.chipselect = cs; a_s2.read = rd; a_s2.write = wr;
                          a_s2.address = a; a_s2.byteenable = be; a_s2.writedata = wd; end
            3'b100: begin b_s1.chipselect = cs; b_s1.read = rd; b_s1.write = wr;
                          b_s1.address = a; b_s1.byteenable = be; b_s1.writedata = wd; end
            default: begin b_s2.chipselect = cs; b_s2.read = rd; b_s2.write = wr;
                          b_s2.address = a; b_s2.byteenable = be; b_s2.writedata = wd; end
        endcase
    endtask

    task automatic idle_all();
        for (int d = 1; d <= 2; d++)
            for (int p = 0; p < 2; p++) drv(d, p, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
    endtask

    function automatic logic vld(input int d, input int p);
        case ({d[1:0], p[0]})
            3'b010:  return a_s1.readdatavalid;
            3'b011:  return a_s2.readdatavalid;
            3'b100:  return b_s1.readdatavalid;
            default: return b_s2.readdatavalid;
        endcase
    endfunction

    function automatic logic [31:0] dat(input int d, input int p);
        case ({d[1:0], p[0]})
            3'b010:  return a_s1.readdata;
            3'b011:  return a_s2.readdata;
            3'b100:  return b_s1.readdata;
            default: return b_s2.readdata;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr1(input int p, input logic [3:0] a, input logic [3:0] be, input logic [31:0] wd);
        drv(1, p, 1'b1, 1'b0, 1'b1, a, be, wd);
        step();
        idle_all();
    endtask

    // Single read on dut1: valid must be low in the accept cycle, high for one cycle, then data holds.
    task automatic rd1(input string nm, input int p, input logic [3:0] a, input logic [31:0] exp);
        logic v0, v1, v2;
        logic [31:0] d1, d2;
        drv(1, p, 1'b1, 1'b1, 1'b0, a, 4'd0, 32'd0);
        #1 v0 = vld(1, p);
        @(negedge clk);
        #0;
        idle_all();
        v1 = vld(1, p); d1 = dat(1, p);
        @(negedge clk);
        v2 = vld(1, p); d2 = dat(1, p);
        check({nm, ".vld"}, {29'd0, v0, v1, v2}, 32'b010);
        check({nm, ".data"}, d1, exp);
        check({nm, ".hold"}, d2, exp);
    endtask

    task automatic count_wait(input string nm);
        int cnt;
        cnt = 0;
        while (a_s1.waitrequest && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check({nm, ".len"}, cnt, 32'd16);
        check({nm, ".s2"}, {31'd0, a_s2.waitrequest}, 32'd0);
        check({nm, ".dut2"}, {31'd0, b_s1.waitrequest}, 32'd0);
    endtask

    initial begin
        logic [5:0]  vpat;
        logic [31:0] d5;
        logic        flushed;
        int          cnt;

        vecs[0]  = '{1'b0, 1'b1, 4'd5,  4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 4'd5,  4'h3, 32'h00001234, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 4'd5,  4'h0, 32'h0,        32'hDEAD1234};
        vecs[3]  = '{1'b1, 1'b0, 4'd5,  4'h0, 32'h0,        32'hDEAD1234};
        vecs[4]  = '{1'b1, 1'b1, 4'd9,  4'h1, 32'h000000AB, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 4'd9,  4'h8, 32'hCD000000, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 4'd9,  4'h0, 32'h0,        32'hCD0000AB};
        vecs[7]  = '{1'b0, 1'b1, 4'd15, 4'hF, 32'h12345678, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 4'd15, 4'h0, 32'h0,        32'h12345678};
        vecs[9]  = '{1'b0, 1'b1, 4'd0,  4'h0, 32'hFFFFFFFF, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 4'd0,  4'h0, 32'h0,        32'h0};

        reset_n = 1'b0; clken1 = 1'b1; clken2 = 1'b1;
        idle_all();
        repeat (3) @(negedge clk);
        check("rst.wait1", {31'd0, a_s1.waitrequest}, 32'd1);
        check("rst.wait2", {31'd0, b_s2.waitrequest}, 32'd1);
        check("rst.vld",   {31'd0, a_s1.readdatavalid}, 32'd0);
        check("rst.data",  a_s2.readdata, 32'd0);

        // power-on clear, then every word reads back zero
        reset_n = 1'b1;
        count_wait("clear1");
        for (int a = 0; a < 16; a++) rd1($sformatf("zero%0d", a), a % 2, a[3:0], 32'd0);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) wr1(vecs[i].port, vecs[i].addr, vecs[i].be, vecs[i].wd);
            else            rd1($sformatf("vec%0d", i), vecs[i].port, vecs[i].addr, vecs[i].exp);
        end

        // same-cycle collision merge
        drv(1, 0, 1'b1, 1'b0, 1'b1, 4'd7, 4'b1100, 32'h11111111);
        drv(1, 1, 1'b1, 1'b0, 1'b1, 4'd7, 4'b0110, 32'h22222222);
        step();
        idle_all();
        rd1("merge7", 0, 4'd7, 32'h11112200);

        // cross-port read-during-write returns old data, new data next cycle
        drv(1, 0, 1'b1, 1'b0, 1'b1, 4'd3, 4'hF, 32'hAAAA5555);
        drv(1, 1, 1'b1, 1'b1, 1'b0, 4'd3, 4'h0, 32'h0);
        step();
        drv(1, 0, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
        check("rdw.old.vld",  {31'd0, vld(1, 1)}, 32'd1);
        check("rdw.old.data", dat(1, 1), 32'h0);
        step();
        idle_all();
        check("rdw.new.vld",  {31'd0, vld(1, 1)}, 32'd1);
        check("rdw.new.data", dat(1, 1), 32'hAAAA5555);
        @(negedge clk);
        check("rdw.end.vld",  {31'd0, vld(1, 1)}, 32'd0);

        // READ_LAT=2 with a 3-cycle clken stall; commands during the stall are ignored
        drv(2, 0, 1'b1, 1'b0, 1'b1, 4'd2, 4'hF, 32'h5A5AC3C3);
        step();
        idle_all();
        drv(2, 0, 1'b1, 1'b1, 1'b0, 4'd2, 4'h0, 32'h0);
        @(posedge clk);
        vpat = '0; d5 = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                clken2 = 1'b0;
                drv(2, 0, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
                drv(2, 1, 1'b1, 1'b0, 1'b1, 4'd2, 4'hF, 32'hFFFFFFFF);
            end
            if (k == 4) begin
                clken2 = 1'b1;
                idle_all();
            end
            #1;
            vpat[k-1] = vld(2, 0);
            if (k == 5) d5 = dat(2, 0);
        end
        check("stall.vld",  {26'd0, vpat}, 32'b010000);
        check("stall.data", d5, 32'h5A5AC3C3);
        @(negedge clk);
        drv(2, 1, 1'b1, 1'b1, 1'b0, 4'd2, 4'h0, 32'h0);
        step();
        idle_all();
        check("stall.lat2.early", {31'd0, vld(2, 1)}, 32'd0);
        @(negedge clk);
        check("stall.lat2.vld",  {31'd0, vld(2, 1)}, 32'd1);
        check("stall.nowrite",   dat(2, 1), 32'h5A5AC3C3);

        // reset with a read in flight, then reset again mid-clear
        check("pre_rst.hold", dat(1, 0), 32'h11112200);
        drv(2, 0, 1'b1, 1'b1, 1'b0, 4'd2, 4'h0, 32'h0);
        @(posedge clk);
        #1;
        idle_all();
        reset_n = 1'b0;
        #1;
        check("rst2.data1", dat(1, 0), 32'h0);
        check("rst2.data2", dat(2, 0), 32'h0);
        check("rst2.wait",  {31'd0, a_s1.waitrequest}, 32'd1);
        flushed = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        if (vld(2, 0)) flushed = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst3.wait", {31'd0, a_s2.waitrequest}, 32'd1);
        check("rst3.vld",  {31'd0, vld(1, 0)}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        count_wait("clear2");
        cnt = 0;
        while (cnt < 4) begin
            if (vld(2, 0)) flushed = 1'b0;
            cnt++;
            @(negedge clk);
        end
        check("flush.vld", {31'd0, flushed}, 32'd1);
        rd1("reclear9", 0, 4'd9, 32'd0);
        rd1("reclear15", 1, 4'd15, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
